// File: rtl/data_mem_responder.sv
// Data-memory endpoint: masked doubleword writes, aligned doubleword reads
// returned in order after a fixed latency through a credit-protected FIFO.
module data_mem_responder #(
    parameter int unsigned DEPTH      = 4096,
    parameter logic [63:0] BASE_ADDR  = 64'h0000_0000_0002_0000,
    parameter int unsigned LATENCY    = 2,
    parameter int unsigned RESP_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_mem_req_i,
    input  logic [63:0] data_mem_addr_i,
    input  logic        data_mem_wr_i,
    input  logic [63:0] data_mem_wr_data_i,
    input  logic [7:0]  data_mem_mask_i,
    output logic        data_mem_ready_o,
    output logic        req_resp_valid_o,
    output logic [63:0] req_rd_data_o,
    input  logic        req_rd_ready_i,
    output logic        oob_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int unsigned CW = $clog2(RESP_DEPTH + 1);

    logic [63:0]   mem_q [DEPTH];
    logic [63:0]   fifo_q [RESP_DEPTH];

    logic [63:0]   offset;
    logic [63:0]   word_idx;
    logic          in_range;
    logic          accept;
    logic          rd_accept;
    logic          wr_accept;
    logic [63:0]   rd_word;

    logic          push_valid;
    logic [63:0]   push_data;
    logic          pop;
    logic          fifo_empty;
    logic          fifo_full;

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [CW-1:0] outst_q, outst_d;
    logic          oob_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Address decode; the subtraction wraps so addresses below the base fail the range check
    assign offset    = data_mem_addr_i - BASE_ADDR;
    assign word_idx  = offset >> 3;
    assign in_range  = (data_mem_addr_i >= BASE_ADDR) && (word_idx < 64'(DEPTH));

    // Credit is reserved per read, so ready depends only on the outstanding count
    assign data_mem_ready_o = (outst_q < CW'(RESP_DEPTH));
    assign accept    = data_mem_req_i & data_mem_ready_o;
    assign rd_accept = accept & ~data_mem_wr_i;
    assign wr_accept = accept & data_mem_wr_i & in_range;
    assign rd_word   = in_range ? mem_q[word_idx[AW-1:0]] : '0;

    // Byte-masked array write; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (wr_accept && !reset) begin
            for (int i = 0; i < 8; i++) begin
                if (data_mem_mask_i[i]) begin
                    mem_q[word_idx[AW-1:0]][8*i +: 8] <= data_mem_wr_data_i[8*i +: 8];
                end
            end
        end
    end

    // Delay line: LATENCY-1 register stages, the FIFO register supplies the last cycle
    generate
        if (LATENCY == 1) begin : g_dl_bypass
            assign push_valid = rd_accept;
            assign push_data  = rd_word;
        end else begin : g_dl
            logic [LATENCY-2:0] dl_valid_q;
            logic [63:0]        dl_data_q [LATENCY-1];

            // Valid bits are cleared by reset so in-flight reads are dropped
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    dl_valid_q <= '0;
                end else begin
                    dl_valid_q[0] <= rd_accept;
                    for (int s = 1; s < int'(LATENCY) - 1; s++) begin
                        dl_valid_q[s] <= dl_valid_q[s-1];
                    end
                end
            end

            // Data stages carry no reset; they are qualified by the valid bits
            always_ff @(posedge clk) begin
                dl_data_q[0] <= rd_word;
                for (int s = 1; s < int'(LATENCY) - 1; s++) begin
                    dl_data_q[s] <= dl_data_q[s-1];
                end
            end

            assign push_valid = dl_valid_q[LATENCY-2];
            assign push_data  = dl_data_q[LATENCY-2];
        end
    endgenerate

    assign fifo_empty       = (fifo_cnt_q == '0);
    assign fifo_full        = (fifo_cnt_q == CW'(RESP_DEPTH));
    assign req_resp_valid_o = ~fifo_empty;
    assign req_rd_data_o    = fifo_empty ? '0 : fifo_q[rd_ptr_q];
    assign pop              = req_resp_valid_o & req_rd_ready_i;
    assign oob_o            = oob_q;

    // Next-state for FIFO pointers, occupancy and read credit
    always_comb begin
        rd_ptr_d   = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d   = push_valid ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        if (push_valid && !pop) begin
            fifo_cnt_d = fifo_cnt_q + 1'b1;
        end else if (!push_valid && pop) begin
            fifo_cnt_d = fifo_cnt_q - 1'b1;
        end
        outst_d = outst_q;
        if (rd_accept && !pop) begin
            outst_d = outst_q + 1'b1;
        end else if (!rd_accept && pop) begin
            outst_d = outst_q - 1'b1;
        end
    end

    // Control registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            outst_q    <= '0;
            oob_q      <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            outst_q    <= outst_d;
            oob_q      <= accept & ~in_range;
        end
    end

    // FIFO storage write
    always_ff @(posedge clk) begin
        if (push_valid) begin
            fifo_q[wr_ptr_q] <= push_data;
        end
    end

    // Credit accounting makes a push into a full FIFO unreachable
    a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(push_valid && fifo_full));
    a_credit_bound: assert property (@(posedge clk) disable iff (reset) outst_q <= CW'(RESP_DEPTH));

endmodule
